// File: rtl/apb_fabric_pkg.sv
// Shared types and helpers for the APB fabric: FSM state encoding and page decode.
package apb_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        DONE     = 2'd3
    } fab_state_e;

    // Page = top pb bits of an aw-bit address (address zero-extended to 32 bits).
    function automatic int unsigned page_of(input logic [31:0] addr, input int aw, input int pb);
        logic [31:0] w_sh;
        w_sh = addr >> (aw - pb);
        return w_sh & ((32'd1 << pb) - 32'd1);
    endfunction

endpackage

// File: rtl/apb_watchdog.sv
// Access-phase watchdog: clearable, saturating cycle counter that flags the last allowed cycle.
module apb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != SAT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/apb_fabric.sv
// APB interconnect: decodes the address page of the I/O master onto one of NUM_SLAVES
// peripherals over a registered shared slave bus, with unmapped-page and watchdog errors.
module apb_fabric
    import apb_fabric_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int PAGE_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             m_psel,
    input  logic                             m_penable,
    input  logic                             m_pwrite,
    input  logic [ADDR_WIDTH-1:0]            m_paddr,
    input  logic [DATA_WIDTH-1:0]            m_pwdata,
    output logic [DATA_WIDTH-1:0]            m_prdata,
    output logic                             m_pready,
    output logic                             m_pslverr,
    output logic [NUM_SLAVES-1:0]            s_psel,
    output logic                             s_penable,
    output logic                             s_pwrite,
    output logic [ADDR_WIDTH-1:0]            s_paddr,
    output logic [DATA_WIDTH-1:0]            s_pwdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata,
    input  logic [NUM_SLAVES-1:0]            s_pready,
    input  logic [NUM_SLAVES-1:0]            s_pslverr,
    input  logic                             err_clear,
    output logic                             err_sticky,
    output logic [ADDR_WIDTH-1:0]            err_addr,
    output logic                             timeout_pulse
);
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    fab_state_e              r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_write;
    logic [SW-1:0]           r_idx;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic                    r_slverr;
    logic                    r_timeout;
    logic                    r_err_sticky;
    logic [ADDR_WIDTH-1:0]   r_err_addr;

    int unsigned             w_page;
    logic                    w_mapped;
    logic                    w_setup;
    logic                    w_access;
    logic                    w_expire;
    logic                    w_sel_ready;
    logic                    w_sel_err;
    logic [DATA_WIDTH-1:0]   w_sel_rdata;
    logic                    w_err_evt;
    logic [ADDR_WIDTH-1:0]   w_err_src;
    logic [DATA_WIDTH-1:0]   w_rdata_arr [NUM_SLAVES];

    assign w_page   = page_of(32'(m_paddr), ADDR_WIDTH, PAGE_BITS);
    assign w_mapped = (w_page < unsigned'(NUM_SLAVES));
    assign w_setup  = (r_state == S_SETUP);
    assign w_access = (r_state == S_ACCESS);

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_rdata
        assign w_rdata_arr[k] = s_prdata[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_sel_ready = s_pready[r_idx];
    assign w_sel_err   = s_pslverr[r_idx];
    assign w_sel_rdata = w_rdata_arr[r_idx];

    apb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_clear  (w_setup),
        .i_enable (w_access),
        .o_expire (w_expire)
    );

    // An unmapped access errors before anything is latched, so its address comes straight from the master.
    assign w_err_evt = ((r_state == IDLE) && m_psel && !w_mapped)
                     || (w_access && w_sel_ready && w_sel_err)
                     || (w_access && !w_sel_ready && w_expire);
    assign w_err_src = (r_state == IDLE) ? m_paddr : r_addr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_idx     <= '0;
            r_prdata  <= '0;
            r_slverr  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_slverr  <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (m_psel) begin
                        r_addr  <= m_paddr;
                        r_wdata <= m_pwdata;
                        r_write <= m_pwrite;
                        r_idx   <= SW'(w_page);
                        if (w_mapped) begin
                            r_state <= S_SETUP;
                        end else begin
                            r_state  <= DONE;
                            r_slverr <= 1'b1;
                            r_prdata <= '0;
                        end
                    end
                end
                S_SETUP: r_state <= S_ACCESS;
                S_ACCESS: begin
                    if (w_sel_ready) begin
                        r_state  <= DONE;
                        r_prdata <= w_sel_rdata;
                        r_slverr <= w_sel_err;
                    end else if (w_expire) begin
                        r_state   <= DONE;
                        r_prdata  <= '0;
                        r_slverr  <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A new error in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_sticky <= 1'b0;
            r_err_addr   <= '0;
        end else if (w_err_evt) begin
            r_err_sticky <= 1'b1;
            r_err_addr   <= w_err_src;
        end else if (err_clear) begin
            r_err_sticky <= 1'b0;
        end
    end

    always_comb begin
        s_psel = '0;
        if (w_setup || w_access) s_psel[r_idx] = 1'b1;
    end

    assign s_penable     = w_access;
    assign s_pwrite      = r_write;
    assign s_paddr       = r_addr;
    assign s_pwdata      = r_wdata;
    assign m_prdata      = r_prdata;
    assign m_pready      = (r_state == DONE);
    assign m_pslverr     = r_slverr;
    assign timeout_pulse = r_timeout;
    assign err_sticky    = r_err_sticky;
    assign err_addr      = r_err_addr;

endmodule

// File: tb/tb_apb_fabric.sv
// Directed + randomized bench for apb_fabric against a transaction-level latency/data/error model.
module tb_apb_fabric;
    localparam int NS = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              m_psel, m_penable, m_pwrite;
    logic [AW-1:0]     m_paddr;
    logic [DW-1:0]     m_pwdata;
    logic [DW-1:0]     m_prdata;
    logic              m_pready, m_pslverr;
    logic [NS-1:0]     s_psel;
    logic              s_penable, s_pwrite;
    logic [AW-1:0]     s_paddr;
    logic [DW-1:0]     s_pwdata;
    logic [NS*DW-1:0]  s_prdata;
    logic [NS-1:0]     s_pready, s_pslverr;
    logic              err_clear;
    logic              err_sticky;
    logic [AW-1:0]     err_addr;
    logic              timeout_pulse;

    always #5 clk = ~clk;

    apb_fabric #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PAGE_BITS(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr),
        .err_clear(err_clear), .err_sticky(err_sticky), .err_addr(err_addr),
        .timeout_pulse(timeout_pulse)
    );

    // Behavioural slaves: respond after cfg_wait access cycles, store writes unless erroring.
    int         cfg_wait [NS];
    bit         cfg_err  [NS];
    int         acc_cnt;
    logic [7:0] slv_mem  [NS][256];

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) acc_cnt <= 0;
        else if (s_penable) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(posedge clk) begin
        for (int k = 0; k < NS; k++)
            if (s_psel[k] && s_penable && s_pready[k] && s_pwrite && !s_pslverr[k])
                slv_mem[k][s_paddr[7:0]] <= s_pwdata;
    end

    always_comb begin
        s_pready  = '0;
        s_pslverr = '0;
        s_prdata  = '0;
        for (int k = 0; k < NS; k++) begin
            s_prdata[k*DW +: DW] = slv_mem[k][s_paddr[7:0]];
            if (s_psel[k] && s_penable && (acc_cnt >= cfg_wait[k])) begin
                s_pready[k]  = 1'b1;
                s_pslverr[k] = cfg_err[k];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs_all();
        return 64'({m_prdata, m_pready, m_pslverr, s_psel, s_penable, s_pwrite, s_paddr,
                    s_pwdata, err_sticky, err_addr, timeout_pulse});
    endfunction

    // Results of the most recent transfer, cycle 0 = master setup cycle.
    int         t_lat, t_tp, t_pfirst, t_plast;
    logic [7:0] t_rd;
    logic       t_err, t_spok;
    logic [3:0] t_pval, t_pdone;

    task automatic xfer(input logic [15:0] a, input logic [7:0] d, input logic w, input logic clr);
        t_lat = -1; t_tp = 0; t_pfirst = -1; t_plast = -1; t_pval = '0; t_pdone = '0;
        t_spok = 1'b1; t_rd = '0; t_err = 1'b0;
        m_psel = 1'b1; m_penable = 1'b0; m_paddr = a; m_pwdata = d; m_pwrite = w; err_clear = clr;
        for (int c = 0; c < 200 && t_lat < 0; c++) begin
            @(negedge clk);
            if (s_psel != '0) begin
                if (t_pfirst < 0) t_pfirst = c;
                t_plast = c;
                t_pval  = s_psel;
                if (s_paddr !== a || s_pwdata !== d || s_pwrite !== w) t_spok = 1'b0;
            end
            if (timeout_pulse) t_tp++;
            if (m_pready) begin
                t_lat = c; t_rd = m_prdata; t_err = m_pslverr; t_pdone = s_psel;
            end
            @(posedge clk); #1;
            m_penable = 1'b1;
            err_clear = 1'b0;
        end
        m_psel = 1'b0; m_penable = 1'b0;
        chk("xfer_completed_in_bound", 64'(t_lat >= 0), 64'd1);
    endtask

    // Transaction-level reference state.
    logic [7:0]  ref_mem [NS][256];
    bit          ref_vld [NS][256];
    logic        exp_sticky;
    logic [15:0] exp_eaddr;

    task automatic run_check(input string tag, input logic [15:0] a, input logic [7:0] d,
                             input logic w, input logic clr);
        int  p;
        bit  unm, tmo, e;
        int  lat;
        p   = int'(a[15:8]);
        unm = (p >= NS);
        tmo = !unm && (cfg_wait[p] >= TO);
        e   = unm || tmo || cfg_err[p];
        lat = unm ? 1 : (tmo ? TO + 2 : 3 + cfg_wait[p]);
        xfer(a, d, w, clr);
        chk({tag, "_lat"}, 64'(t_lat), 64'(lat));
        chk({tag, "_slverr"}, 64'(t_err), 64'(e));
        chk({tag, "_tpulse"}, 64'(t_tp), 64'(tmo ? 1 : 0));
        chk({tag, "_psel_at_done"}, 64'(t_pdone), 64'd0);
        if (unm) begin
            chk({tag, "_psel_none"}, 64'(t_pfirst), 64'(-1));
        end else begin
            chk({tag, "_psel_onehot"}, 64'(t_pval), 64'(1 << p));
            chk({tag, "_psel_window"}, 64'({t_pfirst, t_plast}), 64'({32'd1, 32'(lat - 1)}));
            chk({tag, "_bus_stable"}, 64'(t_spok), 64'd1);
        end
        if (unm || tmo) chk({tag, "_rdata_zero"}, 64'(t_rd), 64'd0);
        else if (!w && ref_vld[p][a[7:0]]) chk({tag, "_rdata"}, 64'(t_rd), 64'(ref_mem[p][a[7:0]]));
        if (e) begin
            exp_sticky = 1'b1; exp_eaddr = a;
        end else if (w) begin
            ref_mem[p][a[7:0]] = d; ref_vld[p][a[7:0]] = 1'b1;
        end
        chk({tag, "_sticky"}, 64'(err_sticky), 64'(exp_sticky));
        chk({tag, "_err_addr"}, 64'(err_addr), 64'(exp_eaddr));
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        n_rst = 1'b0; m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
        m_paddr = '0; m_pwdata = '0; err_clear = 1'b0;
        exp_sticky = 1'b0; exp_eaddr = '0;
        for (int k = 0; k < NS; k++) begin
            cfg_wait[k] = 0; cfg_err[k] = 1'b0;
            for (int j = 0; j < 256; j++) ref_vld[k][j] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs_all(), 64'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;

        run_check("wr_0103", 16'h0103, 8'h5A, 1'b1, 1'b0);
        chk("wr_0103_psel_val", 64'(t_pval), 64'b0010);

        run_check("wr_0002", 16'h0002, 8'hC3, 1'b1, 1'b0);
        cfg_wait[0] = 2;
        run_check("rd_0002", 16'h0002, 8'h00, 1'b0, 1'b0);
        chk("rd_0002_value", 64'(t_rd), 64'hC3);
        chk("rd_0002_latency", 64'(t_lat), 64'd5);
        cfg_wait[0] = 0;

        run_check("unmapped_0700", 16'h0700, 8'h11, 1'b0, 1'b0);
        chk("unmapped_err_addr", 64'(err_addr), 64'h0700);

        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        exp_sticky = 1'b0;
        @(negedge clk);
        chk("err_clear", 64'(err_sticky), 64'd0);
        @(posedge clk); #1;

        run_check("set_wins", 16'h0500, 8'h00, 1'b0, 1'b1);

        cfg_wait[2] = 1000;
        run_check("timeout", 16'h0210, 8'h00, 1'b0, 1'b0);
        chk("timeout_cycle", 64'(t_lat), 64'd10);
        cfg_wait[2] = 0;

        run_check("b2b_first", 16'h0011, 8'h3C, 1'b1, 1'b0);
        run_check("b2b_second", 16'h0311, 8'h4D, 1'b1, 1'b0);

        cfg_wait[1] = 1000;
        m_psel = 1'b1; m_paddr = 16'h0120; m_pwrite = 1'b0; m_pwdata = 8'h00;
        @(posedge clk); #1;
        m_penable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_access_bus", 64'({s_psel, s_penable}), 64'({4'b0010, 1'b1}));
        n_rst = 1'b0;
        #1;
        chk("mid_reset_outputs", outs_all(), 64'd0);
        m_psel = 1'b0; m_penable = 1'b0;
        exp_sticky = 1'b0; exp_eaddr = '0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_hold_quiet", outs_all(), 64'd0);
        end
        cfg_wait[1] = 0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        run_check("post_reset", 16'h0121, 8'h77, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = {8'($urandom_range(0, 5)), 4'h0, 4'($urandom_range(0, 15))};
            d = 8'($urandom);
            w = 1'($urandom_range(0, 1));
            for (int k = 0; k < NS; k++) begin
                cfg_wait[k] = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 3));
                cfg_err[k]  = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 4) == 0) begin
                err_clear = 1'b1;
                @(posedge clk); #1;
                err_clear = 1'b0;
                exp_sticky = 1'b0;
            end
            run_check("rnd", a, d, w, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
